// File: rtl/processor_mc.sv
// processor_mc: multi-cycle core with one request/ready memory port and FETCH/DECODE/EXEC/MEM/WB/STOP sequencing.
// Define PROC_MC_MUL_EN to make opcode 0x05 a multiply; without it 0x05 is illegal.
module processor_mc #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 16,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);
    localparam int RW = $clog2(NREGS);
    localparam logic [4:0] OP_ADDI = 5'h08, OP_LW = 5'h10, OP_SW = 5'h11;
    localparam logic [4:0] OP_BEQ = 5'h18, OP_J = 5'h19, OP_HALT = 5'h1f;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, STOP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [XLEN-1:0]   rf_q [NREGS];
    logic [XLEN-1:0]   rf_d [NREGS];
    logic              illegal_q, illegal_d;

    logic [4:0]      op;
    logic [3:0]      rd, rs, rt;
    logic [XLEN-1:0] imm, alu;
    logic            is_rr, use_rd, use_rs, use_rt, known, bad_idx;

    assign op  = ir_q[31:27];
    assign rd  = ir_q[26:23];
    assign rs  = ir_q[22:19];
    assign rt  = ir_q[18:15];
    assign imm = {{(XLEN-15){ir_q[14]}}, ir_q[14:0]};

    function automatic logic oob(input logic [3:0] idx);
        return (NREGS == 8) && idx[3];
    endfunction

    always_comb begin
`ifdef PROC_MC_MUL_EN
        is_rr = op <= 5'h05;
`else
        is_rr = op <= 5'h04;
`endif
        use_rd  = is_rr || op == OP_ADDI || op == OP_LW;
        use_rs  = use_rd || op == OP_SW || op == OP_BEQ;
        use_rt  = is_rr || op == OP_SW || op == OP_BEQ;
        known   = use_rs || op == OP_J || op == OP_HALT;
        bad_idx = (use_rd && oob(rd)) || (use_rs && oob(rs)) || (use_rt && oob(rt));
    end

    // Effective address (a + imm) is the fall-through for ADDI/LW/SW.
    always_comb begin
        alu = a_q + imm;
        case (op)
            5'h00: alu = a_q + b_q;
            5'h01: alu = a_q - b_q;
            5'h02: alu = a_q & b_q;
            5'h03: alu = a_q | b_q;
            5'h04: alu = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
`ifdef PROC_MC_MUL_EN
            5'h05: alu = a_q * b_q;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        rf_d      = rf_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: if (mem_ready) begin
                ir_d    = mem_rdata[31:0];
                pc_d    = pc_q + ADDR_W'(1);
                state_d = DECODE;
            end
            DECODE: begin
                a_d       = rf_q[rs[RW-1:0]];
                b_d       = rf_q[rt[RW-1:0]];
                illegal_d = !known || bad_idx;
                state_d   = (!known || bad_idx || op == OP_HALT) ? STOP : EXEC;
            end
            EXEC: begin
                res_d   = alu;
                state_d = (op == OP_LW || op == OP_SW) ? MEM :
                          (op == OP_BEQ || op == OP_J) ? FETCH : WB;
                if (op == OP_BEQ && a_q == b_q)
                    pc_d = pc_q + imm[ADDR_W-1:0];
                if (op == OP_J)
                    pc_d = ir_q[ADDR_W-1:0];
            end
            MEM: if (mem_ready) begin
                res_d   = (op == OP_LW) ? mem_rdata : res_q;
                state_d = (op == OP_LW) ? WB : FETCH;
            end
            WB: begin
                if (rd != 4'd0)
                    rf_d[rd[RW-1:0]] = res_q;
                state_d = FETCH;
            end
            STOP: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
            rf_q      <= rf_d;
        end
    end

    // Gating with reset makes an in-flight request vanish the moment reset asserts.
    assign mem_req   = reset && (state_q == FETCH || state_q == MEM);
    assign mem_we    = reset && state_q == MEM && op == OP_SW;
    assign mem_addr  = (state_q == MEM) ? res_q[ADDR_W-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign halted    = state_q == STOP;
    assign illegal   = illegal_q;
endmodule
